// File: rtl/stack_datapath.sv
// Maze-search datapath: a 64x6 cell stack, visited map and neighbour evaluator driven by an external controller.
// Optional PATH_CHECKSUM_EN adds a modulo-256 running sum of the popped path cells (path_sum).
module stack_datapath #(
  parameter logic [5:0] GOAL_XY = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_init,
  input  logic        updater,
  input  logic        alu,
  input  logic        res_updater,
  input  logic        cal_res,
  input  logic        poping,
  input  logic        dont_check,
  input  logic [63:0] maze_map,
  output logic        updated,
  output logic        backtrack,
  output logic        done,
  output logic        cal_update,
  output logic        path_valid,
  output logic [5:0]  path_xy,
  output logic        found,
  output logic [6:0]  path_len
`ifdef PATH_CHECKSUM_EN
  ,
  output logic [7:0]  path_sum
`endif
);

  logic [5:0]  r_stack [64];
  logic [6:0]  r_sp;
  logic [5:0]  r_cur;
  logic [63:0] r_visited;
  logic [63:0] r_maze;
  logic [5:0]  r_cand;
  logic        r_cand_ok;
  logic        r_found;
  logic        r_updater_q;
  logic        r_updated;
  logic        r_backtrack;
  logic        r_cal_update;
  logic        r_path_valid;
  logic [5:0]  r_path_xy;
  // Cleared by rst, set by load_init: every other strobe is ignored until a new search is loaded.
  logic        r_armed;

  logic        w_upd_edge;
  logic        w_pop;
  logic        w_push;
  logic        w_alu;
  logic        w_res;
  logic [5:0]  w_top_idx;
  logic [5:0]  w_par_idx;
  logic [2:0]  w_x;
  logic [2:0]  w_y;
  logic [5:0]  w_nb [4];
  logic [3:0]  w_in_range;
  logic [3:0]  w_nb_ok;
  logic [5:0]  w_cand;
  logic        w_at_goal;

  assign w_upd_edge = updater & ~r_updater_q;
  assign w_pop      = r_armed & ~load_init & poping;
  assign w_push     = r_armed & ~load_init & ~poping & w_upd_edge;
  assign w_alu      = r_armed & ~load_init & ~poping & ~w_upd_edge & alu;
  assign w_res      = r_armed & ~load_init & ~poping & ~w_upd_edge & ~alu & res_updater;

  // Low six bits suffice: with sp==64 they wrap to 63 and 62, the right slots.
  assign w_top_idx = r_sp[5:0] - 6'd1;
  assign w_par_idx = r_sp[5:0] - 6'd2;

  assign w_x = r_cur[2:0];
  assign w_y = r_cur[5:3];
  assign w_at_goal = (r_cur == GOAL_XY);

  // Search order: +x, +y, -x, -y.
  assign w_nb[0] = r_cur + 6'd1;
  assign w_nb[1] = r_cur + 6'd8;
  assign w_nb[2] = r_cur - 6'd1;
  assign w_nb[3] = r_cur - 6'd8;
  assign w_in_range = {w_y != 3'd0, w_x != 3'd0, w_y != 3'd7, w_x != 3'd7};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nb
      assign w_nb_ok[gi] = w_in_range[gi] & ~r_maze[w_nb[gi]] & ~r_visited[w_nb[gi]];
    end
  endgenerate

  always_comb begin
    w_cand = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_nb_ok[i]) w_cand = w_nb[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !r_sp[6]) r_stack[r_sp[5:0]] <= r_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp         <= '0;
      r_cur        <= '0;
      r_visited    <= '0;
      r_maze       <= '0;
      r_cand       <= '0;
      r_cand_ok    <= 1'b0;
      r_found      <= 1'b0;
      r_updater_q  <= 1'b0;
      r_updated    <= 1'b0;
      r_backtrack  <= 1'b0;
      r_cal_update <= 1'b0;
      r_path_valid <= 1'b0;
      r_path_xy    <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_updater_q  <= updater;
      r_path_valid <= 1'b0;
      r_cal_update <= 1'b0;
      if (!updater) r_updated <= 1'b0;

      if (load_init) begin
        r_maze      <= maze_map;
        r_cur       <= '0;
        r_sp        <= '0;
        r_visited   <= '0;
        r_found     <= 1'b0;
        r_cand      <= '0;
        r_cand_ok   <= 1'b0;
        r_backtrack <= 1'b0;
        r_updated   <= 1'b0;
        r_armed     <= 1'b1;
      end else if (w_pop) begin
        if (r_sp != 7'd0) begin
          r_path_xy    <= r_stack[w_top_idx];
          r_path_valid <= 1'b1;
          r_sp         <= r_sp - 7'd1;
        end
      end else if (w_push) begin
        if (!r_sp[6]) begin
          r_sp               <= r_sp + 7'd1;
          r_visited[r_cur]   <= 1'b1;
        end
        r_updated <= 1'b1;
      end else if (w_alu) begin
        if (w_at_goal) begin
          r_found     <= 1'b1;
          r_backtrack <= 1'b1;
        end else if (w_nb_ok != 4'd0) begin
          r_cand      <= w_cand;
          r_cand_ok   <= 1'b1;
          r_backtrack <= 1'b0;
        end else if (r_sp >= 7'd2) begin
          // Dead end: drop it and its parent; the controller's next push restores the parent.
          r_sp        <= r_sp - 7'd2;
          r_cur       <= r_stack[w_par_idx];
          r_cand_ok   <= 1'b0;
          r_backtrack <= 1'b0;
        end else begin
          r_cand_ok   <= 1'b0;
          r_found     <= 1'b0;
          r_backtrack <= 1'b1;
        end
      end else if (w_res) begin
        if (r_cand_ok) begin
          r_cur        <= r_cand;
          r_cand_ok    <= 1'b0;
          r_cal_update <= 1'b1;
        end
      end
    end
  end

`ifdef PATH_CHECKSUM_EN
  logic [7:0] r_path_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_path_sum <= '0;
    end else if (load_init) begin
      r_path_sum <= '0;
    end else if (r_path_valid) begin
      r_path_sum <= r_path_sum + {2'b00, r_path_xy};
    end
  end

  assign path_sum = r_path_sum;
`endif

  assign updated    = r_updated & updater & ~dont_check;
  assign backtrack  = r_backtrack & ~dont_check;
  assign done       = cal_res & r_armed & (r_sp == 7'd0) & ~dont_check;
  assign cal_update = r_cal_update & ~dont_check;
  assign path_valid = r_path_valid;
  assign path_xy    = r_path_xy;
  assign found      = r_found;
  assign path_len   = r_sp;

endmodule

// File: tb/tb_stack_datapath.sv
// Directed bench for stack_datapath: drives the controller handshake and checks hand-computed paths.
module tb_stack_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_init = 1'b0;
  logic        updater = 1'b0;
  logic        alu = 1'b0;
  logic        res_updater = 1'b0;
  logic        cal_res = 1'b0;
  logic        poping = 1'b0;
  logic        dont_check = 1'b0;
  logic [63:0] maze_map = '0;
  logic        updated;
  logic        backtrack;
  logic        done;
  logic        cal_update;
  logic        path_valid;
  logic [5:0]  path_xy;
  logic        found;
  logic [6:0]  path_len;

  int n_checks = 0;
  int n_pass = 0;
  logic [5:0] beats [$];

  always #5 clk = ~clk;

  stack_datapath #(.GOAL_XY(6'h3F)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_init  (load_init),
    .updater    (updater),
    .alu        (alu),
    .res_updater(res_updater),
    .cal_res    (cal_res),
    .poping     (poping),
    .dont_check (dont_check),
    .maze_map   (maze_map),
    .updated    (updated),
    .backtrack  (backtrack),
    .done       (done),
    .cal_update (cal_update),
    .path_valid (path_valid),
    .path_xy    (path_xy),
    .found      (found),
    .path_len   (path_len)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] m);
    maze_map  = m;
    load_init = 1'b1;
    tick();
    load_init = 1'b0;
  endtask

  // Controller loop: push, evaluate, commit; stops when backtrack rises.
  task automatic run_search(output int iters, output int moves, output int retreats,
                            output int first_retreat_len, output bit timeout);
    int len_before;
    iters = 0; moves = 0; retreats = 0; first_retreat_len = -1; timeout = 1'b1;
    for (int s = 0; s < 200; s++) begin
      iters++;
      updater = 1'b1; tick(); updater = 1'b0; tick();
      len_before = int'(path_len);
      alu = 1'b1; tick(); alu = 1'b0;
      if (backtrack) begin
        timeout = 1'b0;
        break;
      end
      if (int'(path_len) == len_before - 2) begin
        retreats++;
        if (first_retreat_len < 0) first_retreat_len = int'(path_len);
      end
      res_updater = 1'b1; tick(); res_updater = 1'b0;
      if (cal_update) moves++;
    end
    $display("search: iters=%0d moves=%0d retreats=%0d found=%0b len=%0d",
             iters, moves, retreats, found, path_len);
  endtask

  task automatic unwind(output bit timeout);
    beats.delete();
    timeout = 1'b1;
    cal_res = 1'b1;
    #1;
    for (int s = 0; s < 80; s++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      poping = 1'b1; tick(); poping = 1'b0;
      if (path_valid) begin
        beats.push_back(path_xy);
        $display("pop beat %0d: path_xy=%0h len=%0d", beats.size(), path_xy, path_len);
      end
    end
  endtask

  initial begin : stim
    int  iters, moves, retreats, frl;
    bit  to;
    bit  saw_valid;

    tick(); tick();
    check_eq("rst path_len", path_len, 0);
    check_eq("rst found", found, 0);
    check_eq("rst path_valid", path_valid, 0);
    check_eq("rst backtrack", backtrack, 0);
    check_eq("rst updated", updated, 0);
    rst = 1'b0;
    tick();

    // Empty maze: +x along row 0, then +y up column 7 to the goal.
    do_load(64'h0);
    check_eq("load path_len", path_len, 0);
    run_search(iters, moves, retreats, frl, to);
    check_eq("empty timeout", to, 0);
    check_eq("empty found", found, 1);
    check_eq("empty path_len", path_len, 15);
    check_eq("empty moves", moves, 14);
    check_eq("empty retreats", retreats, 0);
    dont_check = 1'b1; #1;
    check_eq("dont_check backtrack", backtrack, 0);
    check_eq("dont_check found", found, 1);
    dont_check = 1'b0;
    unwind(to);
    check_eq("empty unwind timeout", to, 0);
    check_eq("empty beats", beats.size(), 15);
    if (beats.size() == 15) begin
      check_eq("empty first xy", beats[0], 6'h3F);
      check_eq("empty second xy", beats[1], 6'h37);
      check_eq("empty last xy", beats[14], 6'h00);
    end
    check_eq("empty done", done, 1);
    check_eq("empty len after", path_len, 0);
    poping = 1'b1; tick(); poping = 1'b0;
    check_eq("pop empty ignored valid", path_valid, 0);
    check_eq("pop empty ignored len", path_len, 0);
    cal_res = 1'b0; #1;
    check_eq("done needs cal_res", done, 0);

    // Start cell walled in by cells 1 and 8.
    do_load(64'h0000_0000_0000_0102);
    run_search(iters, moves, retreats, frl, to);
    check_eq("iso timeout", to, 0);
    check_eq("iso iters", iters, 1);
    check_eq("iso found", found, 0);
    check_eq("iso path_len", path_len, 1);
    cal_res = 1'b1; #1;
    check_eq("iso done before pop", done, 0);
    unwind(to);
    check_eq("iso beats", beats.size(), 1);
    if (beats.size() == 1) check_eq("iso xy", beats[0], 6'h00);
    check_eq("iso done", done, 1);
    tick();
    check_eq("iso valid one cycle", path_valid, 0);
    cal_res = 1'b0;

    // Only row 0 reachable: seven retreats from (7,0) back to the start.
    do_load(64'h7F7F_7F7F_7F7F_FF00);
    run_search(iters, moves, retreats, frl, to);
    check_eq("dead timeout", to, 0);
    check_eq("dead found", found, 0);
    check_eq("dead moves", moves, 7);
    check_eq("dead retreats", retreats, 7);
    check_eq("dead first retreat len", frl, 6);
    check_eq("dead path_len", path_len, 1);
    unwind(to);
    check_eq("dead beats", beats.size(), 1);
    if (beats.size() == 1) check_eq("dead xy", beats[0], 6'h00);
    check_eq("dead done", done, 1);
    check_eq("dead len after", path_len, 0);
    cal_res = 1'b0;

    // updater held four cycles: single push, updated in cycles 2-4.
    do_load(64'h0);
    updater = 1'b1; #1;
    check_eq("hold c1 updated", updated, 0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_eq($sformatf("hold c%0d updated", c), updated, 1);
      check_eq($sformatf("hold c%0d len", c), path_len, 1);
    end
    tick();
    updater = 1'b0; #1;
    check_eq("hold released updated", updated, 0);
    check_eq("hold single push", path_len, 1);
    tick();

    // dont_check masks updated but the push still happens.
    dont_check = 1'b1;
    updater = 1'b1; tick();
    check_eq("masked updated", updated, 0);
    check_eq("masked push len", path_len, 2);
    updater = 1'b0; tick();
    dont_check = 1'b0;

    // rst in the middle of an unwind.
    do_load(64'h0);
    run_search(iters, moves, retreats, frl, to);
    check_eq("rst-run len", path_len, 15);
    cal_res = 1'b1;
    poping = 1'b1;
    repeat (6) tick();
    poping = 1'b0;
    check_eq("mid-unwind len", path_len, 9);
    check_eq("mid-unwind valid", path_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async rst len", path_len, 0);
    check_eq("async rst valid", path_valid, 0);
    check_eq("async rst found", found, 0);
    check_eq("async rst done", done, 0);
    check_eq("async rst backtrack", backtrack, 0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      poping  = c[0];
      updater = ~c[0];
      tick();
      if (path_valid || updated || path_len != 0) saw_valid = 1'b1;
    end
    poping = 1'b0; updater = 1'b0; cal_res = 1'b0;
    tick();
    check_eq("post-rst quiet", saw_valid, 0);
    check_eq("post-rst len", path_len, 0);
    do_load(64'h0);
    updater = 1'b1; tick(); updater = 1'b0; tick();
    check_eq("rearmed push", path_len, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_datapath.md
STACK_DATAPATH -- requirements
Module: stack_datapath

Interface
REQ-001 Parameter GOAL_XY, default 6'h3F, SHALL be the goal cell {y[2:0],x[2:0]}.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 load_init  in  1  latch maze, reset search to start cell (0,0).
REQ-005 updater  in  1  push current cell; level held until updated.
REQ-006 alu  in  1  evaluate neighbours of current cell.
REQ-007 res_updater  in  1  commit move to chosen neighbour.
REQ-008 cal_res  in  1  result-accumulate strobe during unwind.
REQ-009 poping  in  1  pop one stack entry to path output.
REQ-010 dont_check  in  1  force status outputs low.
REQ-011 maze_map  in  64  wall map, bit y*8+x, 1 = wall; sampled on load_init only.
REQ-012 updated  out  1  push complete.
REQ-013 backtrack  out  1  search terminated (goal or no path).
REQ-014 done  out  1  stack empty during unwind.
REQ-015 cal_update  out  1  one-cycle pulse after each committed move.
REQ-016 path_valid  out  1  path_xy valid this cycle.
REQ-017 path_xy  out  6  popped cell {y,x}, goal first, start last.
REQ-018 found  out  1  goal reached.
REQ-019 path_len  out  7  entries on stack (0..64).

Function
REQ-020 Storage SHALL be a 64x6 stack, pointer sp (7 bits), 64-bit visited map, current cell cur, registered candidate cand/cand_ok.
REQ-021 load_init SHALL: latch maze_map, cur=0, sp=0, visited=0, found=0, cand_ok=0.
REQ-022 Push SHALL occur only on the first cycle of an updater level (updater & ~updater_q): stack[sp]=cur, sp+=1, visited[cur]=1; updated SHALL be 1 the following cycle and remain 1 until updater falls.
REQ-023 On alu, neighbour order SHALL be +x, +y, -x, -y; a neighbour is valid if in 0..7 on both axes, not a wall, not visited; first valid one is registered into cand, cand_ok=1.
REQ-024 On alu with cur==GOAL_XY: found=1, backtrack=1, no evaluation.
REQ-025 On alu with no valid neighbour and sp>=2: sp-=2, cur=stack[sp-2] (parent re-pushed by next updater), backtrack=0, cand_ok=0.
REQ-026 On alu with no valid neighbour and sp<=1: backtrack=1, found=0.
REQ-027 backtrack SHALL be registered, valid from the cycle after alu until the next alu or load_init.
REQ-028 On res_updater with cand_ok=1: cur=cand, cand_ok=0, cal_update=1 next cycle only; with cand_ok=0: no change, no pulse.
REQ-029 done SHALL be combinational (sp==0) while cal_res=1, else 0.
REQ-030 On poping with sp>0: path_xy=stack[sp-1], path_valid=1 next cycle for one cycle, sp-=1; poping with sp==0 SHALL be ignored.
REQ-031 path_len SHALL equal sp at all times.
REQ-032 dont_check=1 SHALL force updated, backtrack, done, cal_update to 0 without altering internal state.
REQ-033 Simultaneous strobes: priority load_init > poping > updater > alu > res_updater; lower ones ignored.

Reset
REQ-034 rst SHALL asynchronously clear sp, cur, visited, maze, cand, cand_ok, found, updater_q, and drive all outputs 0; mid-search rst abandons search with no further outputs until load_init.

Configuration
REQ-035 With PATH_CHECKSUM_EN defined, an 8-bit output path_sum SHALL exist, cleared on load_init/rst, adding {2'b0,path_xy} modulo 256 on each path_valid cycle; without it the port and logic SHALL be absent.

Verification
REQ-036 Empty maze (all 0), full controller sequence -> found=1, 15 path_valid beats, first path_xy=6'h3F, last 6'h00.
REQ-037 Walls at cells 1 and 8 (start isolated) -> backtrack=1 after first alu, found=0, one pop of 6'h00, done=1.
REQ-038 Dead-end corridor: walls all except row 0 and column 7 below (7,0) with (7,1) walled -> repeated REQ-025 retreats, final found=0, done with sp=0.
REQ-039 updater held 4 cycles -> exactly one push, path_len +1, updated high cycles 2-4.
REQ-040 dont_check=1 during push -> updated stays 0, path_len still increments.
REQ-041 rst asserted mid-unwind with path_len=9 -> outputs 0 immediately, path_len=0, no path_valid until new load_init.
